axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2, meaning: consecutive data grants allowed while inst waits.
REQ-002 Parameter ID_INST, default 4'h0, meaning: AXI ID for inst bursts.
REQ-003 Parameter ID_DATA, default 4'h1, meaning: AXI ID for data bursts.
REQ-004 aclk  in  1  single clock; all state on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 inst_req / data_req  in  1  read request, held until matching addr_ok.
REQ-007 inst_addr / data_addr  in  32  burst start address.
REQ-008 inst_len / data_len  in  8  beats minus one (AXI arlen encoding).
REQ-009 inst_size / data_size  in  3  AXI arsize encoding.
REQ-010 inst_addr_ok / data_addr_ok  out  1  request accepted on AR.
REQ-011 inst_rvalid / data_rvalid  out  1  read beat valid for that requester.
REQ-012 inst_rlast / data_rlast  out  1  last beat of burst.
REQ-013 rdata_o  out  32  beat data, shared by both requesters.
REQ-014 rresp_o  out  2  beat response, shared.
REQ-015 arid, araddr, arlen, arsize, arburst, arvalid  out  4/32/8/3/2/1  AXI AR channel.
REQ-016 arready  in  1  AXI AR ready.
REQ-017 rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1  AXI R channel.
REQ-018 rready  out  1  AXI R ready.
REQ-019 id_err  out  1  sticky: R beat with unexpected rid seen.

Function
REQ-020 FSM states IDLE, AR, R; exactly one outstanding burst.
REQ-021 IDLE: if any req, latch winner's addr/len/size/ID and owner, go AR next edge; else stay.
REQ-022 Arbitration: data wins when both request, unless starve_cnt == STARVE_LIMIT, then inst wins.
REQ-023 starve_cnt (2-bit, saturating): +1 on data grant with inst_req high; cleared on inst grant; unchanged otherwise.
REQ-024 AR: arvalid = 1, AR fields from latched values, arburst = 2'b01 (INCR); fields stable until arvalid&arready.
REQ-025 owner's addr_ok = arvalid & arready (combinational, one-cycle pulse); on that edge go R.
REQ-026 Requester dropping req or changing addr in AR shall not alter AR fields.
REQ-027 R: rready = 1; rvalid with rid == latched ID drives owner's rvalid, rlast, rdata_o, rresp_o combinationally; other requester's rvalid = 0.
REQ-028 R: rvalid with rid != latched ID is accepted, not forwarded, sets id_err, does not end burst.
REQ-029 R: matching rvalid & rlast -> IDLE next edge; next arvalid earliest two cycles after rlast beat.
REQ-030 rresp != OKAY forwarded unchanged; no state effect.
REQ-031 Outside R: rready = 0 and both requester rvalid = 0.
REQ-032 Beat count not checked; burst ends only on rlast.

Reset
REQ-033 aresetn low: state IDLE, arvalid = 0, rready = 0, addr_ok = 0, rvalid = 0, starve_cnt = 0, id_err = 0, latched fields 0, asynchronously, including mid-AR or mid-R.
REQ-034 First grant possible on first rising edge after aresetn deasserts.

Structure
REQ-035 State encoding, ID_INST/ID_DATA defaults, AXI burst/resp constants in shared defines header.
REQ-036 Single module; optional sub-module rd_arb_pick (combinational winner + starve_cnt update).

Verification
REQ-037 inst_req alone, addr 32'h1FC0_0000, len 7, arready immediate -> arvalid next cycle, arid 0, arlen 7, arburst 01, inst_addr_ok 1 cycle, 8 inst_rvalid beats, IDLE after rlast.
REQ-038 Both req held continuously, STARVE_LIMIT 2, len 0 -> grant order data, data, inst, data, data, inst.
REQ-039 arready held 0 for 5 cycles while req drops and addr changes to 32'hDEAD_0000 -> araddr stays at latched value; addr_ok only on handshake cycle.
REQ-040 Data burst len 3, beat 2 arrives with rid 4'h3 -> beat dropped, id_err = 1, burst completes after 4 matching beats incl. rlast.
REQ-041 aresetn asserted mid-R on beat 2 of 8 -> all outputs reset immediately; after release, new inst_req granted normally.
REQ-042 rresp 2'b10 on beat 1 -> rresp_o = 2'b10 that cycle, burst continues to rlast.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [3:0] ID_INST_DEF = 4'h0;
  localparam logic [3:0] ID_DATA_DEF = 4'h1;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Burst fields captured at grant time and held for the whole transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    owner_t      owner;
  } ar_req_t;

  // Two-bit saturating increment used by the starvation counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_pick.sv
// Combinational winner selection and starvation-counter update.
// Data normally wins; inst wins once it has waited STARVE_LIMIT data grants.
module axi_rd_arbiter_pick
  import axi_rd_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic [1:0] starve_cnt,
  output logic       grant,
  output logic       winner_data,
  output logic [1:0] starve_nxt
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  logic inst_starved;
  assign inst_starved = inst_req && (starve_cnt == LIMIT);

  // Pick the winner and the counter value to commit if the grant is taken.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    grant       = 1'b0;
    winner_data = 1'b0;
    starve_nxt  = starve_cnt;
    if (data_req && !inst_starved) begin
      grant       = 1'b1;
      winner_data = 1'b1;
      if (inst_req) starve_nxt = sat_inc2(starve_cnt);
    end else if (inst_req) begin
      grant      = 1'b1;
      starve_nxt = 2'd0;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester (inst/data) AXI read arbiter with one outstanding burst.
// IDLE picks a winner and latches its request, AR presents it, R forwards
// matching beats to the owner until rlast.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 2,
  parameter logic [3:0] ID_INST      = ID_INST_DEF,
  parameter logic [3:0] ID_DATA      = ID_DATA_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  input  logic [2:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [7:0]  data_len,
  input  logic [2:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_rvalid,
  output logic        data_rlast,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        id_err
);

  state_t     state, state_nxt;
  ar_req_t    ar_q;
  logic [1:0] starve_cnt, starve_nxt;
  logic       grant, winner_data;
  logic       beat_match;

  axi_rd_arbiter_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .starve_cnt  (starve_cnt),
    .grant       (grant),
    .winner_data (winner_data),
    .starve_nxt  (starve_nxt)
  );

  assign beat_match = rvalid && (rid == ar_q.id);

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = BURST_INCR;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus all handshake and forwarding outputs.
  always_comb begin
    state_nxt    = state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_rvalid  = 1'b0;
    data_rvalid  = 1'b0;
    inst_rlast   = 1'b0;
    data_rlast   = 1'b0;
    rdata_o      = '0;
    rresp_o      = RESP_OKAY;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_AR;
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = ST_R;
          if (ar_q.owner == OWN_DATA) data_addr_ok = 1'b1;
          else                        inst_addr_ok = 1'b1;
        end
      end
      ST_R: begin
        rready = 1'b1;
        if (beat_match) begin
          rdata_o = rdata;
          rresp_o = rresp;
          if (ar_q.owner == OWN_DATA) begin
            data_rvalid = 1'b1;
            data_rlast  = rlast;
          end else begin
            inst_rvalid = 1'b1;
            inst_rlast  = rlast;
          end
          if (rlast) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's request and commit the starvation count on a grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: these are ordinary flops, not a memory array, so they take the
    // async reset like the rest of the control state.
    if (!aresetn) begin
      ar_q       <= '0;
      starve_cnt <= 2'd0;
    end else if (state == ST_IDLE && grant) begin
      starve_cnt <= starve_nxt;
      if (winner_data) ar_q <= '{addr: data_addr, len: data_len, size: data_size,
                                 id: ID_DATA, owner: OWN_DATA};
      else             ar_q <= '{addr: inst_addr, len: inst_len, size: inst_size,
                                 id: ID_INST, owner: OWN_INST};
    end
  end

  // Sticky flag for any R beat whose ID does not belong to the open burst.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                    id_err <= 1'b0;
    else if (state == ST_R && rvalid && !beat_match) id_err <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: arbitration table, directed
// multi-cycle corner cases, then randomized bursts against a simple model.
module tb_axi_rd_arbiter;

  localparam logic [3:0] ID_I = 4'h0;
  localparam logic [3:0] ID_D = 4'h1;
  localparam int         LIM  = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [7:0]  inst_len, data_len;
  logic [2:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_rvalid, inst_rlast;
  logic        data_addr_ok, data_rvalid, data_rlast;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, id_err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_arbiter #(.STARVE_LIMIT(LIM), .ID_INST(ID_I), .ID_DATA(ID_D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len),
    .inst_size(inst_size), .inst_addr_ok(inst_addr_ok),
    .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_req(data_req), .data_addr(data_addr), .data_len(data_len),
    .data_size(data_size), .data_addr_ok(data_addr_ok),
    .data_rvalid(data_rvalid), .data_rlast(data_rlast),
    .rdata_o(rdata_o), .rresp_o(rresp_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .id_err(id_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Drives one complete burst from the slave side and checks every visible
  // output. Called at negedge+1 with requests already set. bad_beat inserts a
  // foreign-ID beat (with rlast high) before that matching beat; err_beat
  // returns SLVERR on that beat; abort_beat asserts reset during that beat.
  task automatic run_burst(input bit own_data, input logic [31:0] exp_addr,
                           input logic [7:0] exp_len, input logic [2:0] exp_size,
                           input int ar_wait, input int bad_beat, input int err_beat,
                           input int abort_beat, input int exp_wait, input string tag);
    int          waited = 0;
    int          b = 0;
    bit          bad_done = 1'b0;
    bit          bad, last;
    logic [3:0]  id;
    logic [31:0] d;
    id = own_data ? ID_D : ID_I;
    do begin
      @(negedge aclk); #1;
      waited++;
    end while (!arvalid && waited < 20);
    check({tag, "/arvalid"}, arvalid, 1);
    if (!arvalid) return;
    if (exp_wait > 0) check({tag, "/ar_latency"}, waited, exp_wait);
    check({tag, "/arid"}, arid, id);
    check({tag, "/araddr"}, araddr, exp_addr);
    check({tag, "/arlen"}, arlen, exp_len);
    check({tag, "/arsize"}, arsize, exp_size);
    check({tag, "/arburst"}, arburst, 2'b01);
    check({tag, "/rready_ar"}, rready, 0);
    for (int i = 0; i < ar_wait; i++) begin
      check({tag, "/ok_stall"}, {inst_addr_ok, data_addr_ok}, 2'b00);
      @(negedge aclk);
      if (own_data) begin data_req = 1'b0; data_addr = 32'hDEAD_0000; end
      else          begin inst_req = 1'b0; inst_addr = 32'hDEAD_0000; end
      #1;
      check({tag, "/araddr_stall"}, araddr, exp_addr);
      check({tag, "/arvalid_stall"}, arvalid, 1);
    end
    arready = 1'b1;
    #1;
    check({tag, "/addr_ok"}, {inst_addr_ok, data_addr_ok}, own_data ? 2'b01 : 2'b10);
    if (own_data) data_req = 1'b0; else inst_req = 1'b0;
    while (b <= int'(exp_len)) begin
      @(negedge aclk);
      arready  = 1'b0;
      bad      = (b == bad_beat) && !bad_done;
      last     = (b == int'(exp_len));
      d        = $urandom;
      rvalid   = 1'b1;
      rdata    = d;
      rid      = bad ? (id ^ 4'h2) : id;
      rlast    = bad ? 1'b1 : last;
      rresp    = (!bad && b == err_beat) ? 2'b10 : 2'b00;
      #1;
      check({tag, "/rready"}, rready, 1);
      check({tag, "/arvalid_r"}, arvalid, 0);
      check({tag, "/inst_rvalid"}, inst_rvalid, !bad && !own_data);
      check({tag, "/data_rvalid"}, data_rvalid, !bad && own_data);
      if (bad) begin
        bad_done = 1'b1;
      end else begin
        check({tag, "/rdata_o"}, rdata_o, d);
        check({tag, "/rresp_o"}, rresp_o, (b == err_beat) ? 2'b10 : 2'b00);
        check({tag, "/rlast"}, {inst_rlast, data_rlast},
              {!own_data && last, own_data && last});
        if (b == abort_beat) begin
          aresetn = 1'b0;
          #1;
          check({tag, "/reset_ctl"},
                {arvalid, rready, inst_addr_ok, data_addr_ok, inst_rvalid,
                 data_rvalid, inst_rlast, data_rlast, id_err}, 9'd0);
          check({tag, "/reset_araddr"}, araddr, 32'd0);
          check({tag, "/reset_arlen"}, {arid, arlen, arsize}, 15'd0);
          return;
        end
        b++;
      end
    end
    @(negedge aclk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    #1;
    check({tag, "/idle_rready"}, rready, 0);
    check({tag, "/idle_arvalid"}, arvalid, 0);
    if (bad_beat >= 0) check({tag, "/id_err"}, id_err, 1);
  endtask

  typedef struct {
    bit inst;
    bit data;
    bit exp_data;
  } arb_vec_t;

  arb_vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  model_starve;
    bit  exp_data, inst_was;
    int  len_i;

    // Grant order with both requesters held, STARVE_LIMIT 2, len 0.
    tbl[0]  = '{1, 1, 1};  tbl[1]  = '{1, 1, 1};  tbl[2]  = '{1, 1, 0};
    tbl[3]  = '{1, 1, 1};  tbl[4]  = '{1, 1, 1};  tbl[5]  = '{1, 1, 0};
    tbl[6]  = '{0, 1, 1};  tbl[7]  = '{1, 0, 0};  tbl[8]  = '{1, 1, 1};
    tbl[9]  = '{1, 1, 1};  tbl[10] = '{1, 1, 0};  tbl[11] = '{0, 1, 1};

    aresetn = 1'b0;
    inst_req = 0; inst_addr = 0; inst_len = 0; inst_size = 0;
    data_req = 0; data_addr = 0; data_len = 0; data_size = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (3) @(negedge aclk);
    #1;
    check("reset/arvalid", arvalid, 0);
    check("reset/rready", rready, 0);
    check("reset/addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("reset/id_err", id_err, 0);
    check("reset/araddr", araddr, 32'd0);

    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].inst && !inst_req) begin
        inst_req = 1'b1; inst_addr = 32'h1000_0000 + 32'(i * 64);
        inst_len = 8'd0; inst_size = 3'd2;
      end else if (!tbl[i].inst) inst_req = 1'b0;
      if (tbl[i].data && !data_req) begin
        data_req = 1'b1; data_addr = 32'h2000_0000 + 32'(i * 64);
        data_len = 8'd0; data_size = 3'd2;
      end else if (!tbl[i].data) data_req = 1'b0;
      run_burst(tbl[i].exp_data, tbl[i].exp_data ? data_addr : inst_addr, 8'd0, 3'd2,
                0, -1, -1, -1, (i == 0) ? 1 : -1, $sformatf("arb%0d", i));
    end

    // Single inst burst of 8 beats, arready immediate.
    inst_req = 1'b1; data_req = 1'b0;
    inst_addr = 32'h1FC0_0000; inst_len = 8'd7; inst_size = 3'd2;
    run_burst(0, 32'h1FC0_0000, 8'd7, 3'd2, 0, -1, -1, -1, 1, "inst8");

    // arready withheld 5 cycles while the requester drops and moves its addr.
    inst_req = 1'b1; inst_addr = 32'h3000_1000; inst_len = 8'd1; inst_size = 3'd1;
    run_burst(0, 32'h3000_1000, 8'd1, 3'd1, 5, -1, -1, -1, 1, "stall");

    // Foreign rid on beat 2 of a 4-beat data burst.
    check("pre_bad/id_err", id_err, 0);
    data_req = 1'b1; data_addr = 32'h4000_0000; data_len = 8'd3; data_size = 3'd2;
    run_burst(1, 32'h4000_0000, 8'd3, 3'd2, 0, 2, -1, -1, 1, "bad_rid");

    // SLVERR on beat 1 is forwarded and the burst carries on.
    inst_req = 1'b1; inst_addr = 32'h4400_0040; inst_len = 8'd3; inst_size = 3'd2;
    run_burst(0, 32'h4400_0040, 8'd3, 3'd2, 0, -1, 1, -1, 1, "slverr");

    // Reset mid-R on beat 2 of 8, then a normal grant after release.
    inst_req = 1'b1; inst_addr = 32'h4800_0000; inst_len = 8'd7; inst_size = 3'd2;
    run_burst(0, 32'h4800_0000, 8'd7, 3'd2, 0, -1, -1, 2, 1, "abort");
    @(negedge aclk);
    aresetn = 1'b1; rvalid = 1'b0; rlast = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h5000_0000; inst_len = 8'd1; inst_size = 3'd2;
    run_burst(0, 32'h5000_0000, 8'd1, 3'd2, 0, -1, -1, -1, 1, "post_reset");

    // Randomized bursts against a starvation-count model.
    model_starve = 0;
    for (int n = 0; n < 40; n++) begin
      if (!inst_req && ($urandom % 2 == 0)) begin
        inst_req = 1'b1; inst_addr = $urandom; inst_len = 8'($urandom % 4);
        inst_size = 3'($urandom % 3);
      end
      if (!data_req && ($urandom % 3 != 0)) begin
        data_req = 1'b1; data_addr = $urandom; data_len = 8'($urandom % 4);
        data_size = 3'($urandom % 3);
      end
      if (!inst_req && !data_req) begin
        inst_req = 1'b1; inst_addr = $urandom; inst_len = 8'd0; inst_size = 3'd2;
      end
      inst_was = inst_req;
      exp_data = data_req && !(inst_req && model_starve == LIM);
      len_i    = exp_data ? int'(data_len) : int'(inst_len);
      run_burst(exp_data, exp_data ? data_addr : inst_addr,
                exp_data ? data_len : inst_len, exp_data ? data_size : inst_size,
                int'($urandom % 3),
                ($urandom % 3 == 0) ? int'($urandom % (len_i + 1)) : -1,
                ($urandom % 4 == 0) ? int'($urandom % (len_i + 1)) : -1,
                -1, -1, $sformatf("rnd%0d", n));
      if (!exp_data)     model_starve = 0;
      else if (inst_was) model_starve = (model_starve < 3) ? model_starve + 1 : 3;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
